// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of the shared combinational ALU, with a one-deep response buffer per port.
// Optional build macro ALU_ARB_FIXED_PRIO_EN gives port 0 strict priority instead of round-robin.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [3:0]  req1_ctrl,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic        resp0_zero,
  output logic        resp0_err,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic        resp1_zero,
  output logic        resp1_err,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;

  logic eligible0, eligible1;
  logic grant0, grant1;
  logic sup0, sup1;

  function automatic logic ctrl_supported(input logic [3:0] ctrl);
    case (ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign sup0 = ctrl_supported(req0_ctrl);
  assign sup1 = ctrl_supported(req1_ctrl);

  // A port may be served when its buffer is free or is being drained this same cycle.
  assign eligible0 = req0_valid & (~resp0_valid | resp0_ready);
  assign eligible1 = req1_valid & (~resp1_valid | resp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = ~rst & eligible0;
`else
  // last_grant holds the index of the most recently accepted port.
  logic last_grant;

  assign grant0 = ~rst & eligible0 & (~eligible1 | last_grant);
`endif
  assign grant1 = ~rst & eligible1 & ~grant0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_data1 = '0;
    alu_data2 = '0;
    alu_ctrl  = CTRL_ADD;
    if (grant0) begin
      alu_data1 = req0_data1;
      alu_data2 = req0_data2;
      alu_ctrl  = sup0 ? req0_ctrl : CTRL_ADD;
    end else if (grant1) begin
      alu_data1 = req1_data1;
      alu_data2 = req1_data2;
      alu_ctrl  = sup1 ? req1_ctrl : CTRL_ADD;
    end
  end

  // Unsupported codes are accepted but answered with a fixed error response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_zero   <= 1'b0;
      resp0_err    <= 1'b0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_zero   <= 1'b0;
      resp1_err    <= 1'b0;
    end else begin
      if (grant0) begin
        resp0_valid  <= 1'b1;
        resp0_result <= sup0 ? alu_result : 32'd0;
        resp0_zero   <= sup0 ? alu_zero : 1'b1;
        resp0_err    <= ~sup0;
      end else if (resp0_ready) begin
        resp0_valid  <= 1'b0;
      end
      if (grant1) begin
        resp1_valid  <= 1'b1;
        resp1_result <= sup1 ? alu_result : 32'd0;
        resp1_zero   <= sup1 ? alu_zero : 1'b1;
        resp1_err    <= ~sup1;
      end else if (resp1_ready) begin
        resp1_valid  <= 1'b0;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic against a behavioural model.
// Honours ALU_ARB_FIXED_PRIO_EN when the same macro is defined for the build.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero, resp0_err, resp1_err;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  // Reference state: which port was served last and what each response buffer should hold.
  int          last_port = 1;
  bit          pend_valid [2];
  logic [31:0] pend_result[2];
  bit          pend_zero  [2];
  bit          pend_err   [2];

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_supported(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
  endfunction

  // Stand-in for the shared ALU.
  assign alu_result = alu_ref(alu_data1, alu_data2, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data1(req0_data1), .req0_data2(req0_data2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data1(req1_data1), .req1_data2(req1_data2), .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_err(resp1_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the grant and ALU drive, clocks, then checks both buffers.
  task automatic applyStimulus(input bit r,
                               input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] c0, input bit rr0,
                               input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [3:0] c1, input bit rr1);
    bit          el[2];
    bit          rr[2];
    logic [31:0] a[2], b[2];
    logic [3:0]  c[2];
    logic [31:0] got_res[2];
    logic [31:0] got_flags[2];
    logic [31:0] res;
    int          w;
    rst = r;
    req0_valid = v0; req0_data1 = a0; req0_data2 = b0; req0_ctrl = c0; resp0_ready = rr0;
    req1_valid = v1; req1_data1 = a1; req1_data2 = b1; req1_ctrl = c1; resp1_ready = rr1;
    a[0] = a0; b[0] = b0; c[0] = c0; rr[0] = rr0;
    a[1] = a1; b[1] = b1; c[1] = c1; rr[1] = rr1;
    #1;
    el[0] = v0 && (!pend_valid[0] || rr0);
    el[1] = v1 && (!pend_valid[1] || rr1);
    if (r) w = -1;
    else if (el[0] && el[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (last_port == 0) ? 1 : 0;
`endif
    end
    else if (el[0]) w = 0;
    else if (el[1]) w = 1;
    else w = -1;

    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
    if (w < 0) begin
      checkOutput("alu_data1_idle", alu_data1, 32'd0);
      checkOutput("alu_data2_idle", alu_data2, 32'd0);
      checkOutput("alu_ctrl_idle", {28'd0, alu_ctrl}, 32'd2);
    end else begin
      checkOutput("alu_data1", alu_data1, a[w]);
      checkOutput("alu_data2", alu_data2, b[w]);
      checkOutput("alu_ctrl", {28'd0, alu_ctrl}, is_supported(c[w]) ? {28'd0, c[w]} : 32'd2);
    end

    @(posedge clk);
    if (r) begin
      last_port = 1;
      for (int p = 0; p < 2; p++) begin
        pend_valid[p] = 0; pend_result[p] = 0; pend_zero[p] = 0; pend_err[p] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w == p) begin
          res = alu_ref(a[p], b[p], c[p]);
          pend_valid[p]  = 1;
          pend_result[p] = is_supported(c[p]) ? res : 32'd0;
          pend_zero[p]   = is_supported(c[p]) ? (res == 32'd0) : 1'b1;
          pend_err[p]    = !is_supported(c[p]);
        end else if (pend_valid[p] && rr[p]) begin
          pend_valid[p] = 0;
        end
      end
      if (w >= 0) last_port = w;
    end

    #1;
    got_res[0] = resp0_result; got_flags[0] = {30'd0, resp0_zero, resp0_err};
    got_res[1] = resp1_result; got_flags[1] = {30'd0, resp1_zero, resp1_err};
    checkOutput("resp0_valid", {31'd0, resp0_valid}, {31'd0, pend_valid[0]});
    checkOutput("resp1_valid", {31'd0, resp1_valid}, {31'd0, pend_valid[1]});
    for (int p = 0; p < 2; p++) begin
      if (pend_valid[p] || r) begin
        checkOutput(p == 0 ? "resp0_result" : "resp1_result", got_res[p], pend_result[p]);
        checkOutput(p == 0 ? "resp0_zero_err" : "resp1_zero_err", got_flags[p],
                    {30'd0, pend_zero[p], pend_err[p]});
      end
    end
  endtask

  initial begin
    logic [3:0]  ops[6];
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [3:0]  rc0, rc1;
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h6; ops[4] = 4'h7; ops[5] = 4'hC;

    rst = 1'b1;
    req0_valid = 0; req0_data1 = 0; req0_data2 = 0; req0_ctrl = 0; resp0_ready = 0;
    req1_valid = 0; req1_data1 = 0; req1_data2 = 0; req1_ctrl = 0; resp1_ready = 0;
    @(posedge clk);
    #1;
    $display("[TB] reset and single ADD");
    applyStimulus(1, 1, 1, 1, 4'h2, 0, 1, 1, 1, 4'h2, 0);
    applyStimulus(0, 1, 5, 7, 4'h2, 0, 0, 0, 0, 4'h2, 0);
    checkOutput("add_5_7", resp0_result, 32'd12);
    checkOutput("add_5_7_zero", {31'd0, resp0_zero}, 32'd0);
    checkOutput("add_5_7_err", {31'd0, resp0_err}, 32'd0);

    $display("[TB] contention with responses always consumed");
    applyStimulus(1, 0, 0, 0, 4'h2, 1, 0, 0, 0, 4'h2, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 3, 3, 4'h6, 1, 1, 32'hF0, 32'h0F, 4'h1, 1);
`ifndef ALU_ARB_FIXED_PRIO_EN
      if (i == 0) checkOutput("sub_3_3", {resp0_result[30:0], resp0_zero}, 32'd1);
      if (i == 1) checkOutput("or_f0_0f", resp1_result, 32'hFF);
`endif
    end

    $display("[TB] port 0 response held");
    applyStimulus(1, 0, 0, 0, 4'h2, 1, 0, 0, 0, 4'h2, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 2, 4'h2, 0, 1, 10, 4, 4'h6, 1);
      checkOutput("held_resp0", resp0_result, 32'd3);
    end
    applyStimulus(0, 0, 0, 0, 4'h2, 1, 0, 0, 0, 4'h2, 1);

    $display("[TB] unsupported ctrl and ALU ops");
    applyStimulus(0, 0, 0, 0, 4'h2, 1, 1, 32'h1234, 32'h5, 4'h3, 1);
    checkOutput("bad_ctrl_err", {29'd0, resp1_zero, resp1_err, |resp1_result}, 32'b110);
    applyStimulus(0, 1, 32'hFFFFFFFF, 1, 4'h7, 1, 0, 0, 0, 4'h2, 1);
    checkOutput("slt_unsigned", resp0_result, 32'd0);
    applyStimulus(0, 1, 0, 0, 4'hC, 1, 0, 0, 0, 4'h2, 1);
    checkOutput("nor_0_0", resp0_result, 32'hFFFFFFFF);
    applyStimulus(0, 1, 32'hF0F0, 32'hFF00, 4'h0, 1, 0, 0, 0, 4'h2, 1);
    checkOutput("and_f0f0_ff00", resp0_result, 32'hF000);

    $display("[TB] reset with pending response");
    applyStimulus(0, 1, 9, 1, 4'h2, 0, 0, 0, 0, 4'h2, 0);
    applyStimulus(1, 1, 9, 1, 4'h2, 0, 1, 2, 2, 4'h2, 0);
    checkOutput("rst_clears_resp0", {31'd0, resp0_valid}, 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      rc0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
      rc1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0, ra0, rb0, rc0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, ra1, rb1, rc1, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter sharing the single combinational ALU between the EX stage (port 0) and a secondary requester (port 1, e.g. address-generation or debug unit). Accepts at most one operation per cycle via valid/ready, drives the ALU from the winner, and registers result/zero into a per-port response buffer held until the requester consumes it. Sits between the requesters and the ALU instance; owns all ALU input muxing.

## Interface
- No parameters; data width fixed at 32, ALU control fixed at 4 bits.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  operation request per port
- req0_ready / req1_ready  out  1  grant; accepted when valid & ready same cycle
- req0_data1, req0_data2 / req1_data1, req1_data2  in  32  operands
- req0_ctrl / req1_ctrl  in  4  ALU control code
- resp0_valid / resp1_valid  out  1  response buffered for port
- resp0_ready / resp1_ready  in  1  requester consumes response
- resp0_result / resp1_result  out  32  buffered ALU result
- resp0_zero / resp1_zero  out  1  buffered ALU zero flag
- resp0_err / resp1_err  out  1  op had unsupported ctrl code
- alu_data1, alu_data2  out  32  to ALU operands
- alu_ctrl  out  4  to ALU ctrl_sig
- alu_result  in  32  from ALU
- alu_zero  in  1  from ALU

## Operation
- Eligible port: reqN_valid=1 and no pending response (respN_valid=0), or pending response being consumed this cycle (respN_valid & respN_ready).
- Arbitration each cycle among eligible ports; exactly one reqN_ready high at most; reqN_ready combinational from valid/eligibility/priority register.
- Round-robin: last_grant register (reset 1, so port 0 wins first contention); on contention the port not equal to last_grant wins; last_grant updates only on an accepted request.
- Winner's data1/data2/ctrl drive alu_* combinationally. No grant: alu_data1=alu_data2=0, alu_ctrl=4'b0010 (add), so ALU never holds a stale value.
- Supported ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned compare, as ALU implements), 1100 NOR. Any other code: request still accepted, ALU driven with 0010, response stores result=0, zero=1, err=1.
- On acceptance: respN_result<=alu_result, respN_zero<=alu_zero, respN_err<=0 (or forced values above), respN_valid<=1.
- respN_valid clears on respN_valid & respN_ready unless a new request for that port is accepted same cycle (then reloads, stays 1).
- Response fields stable while respN_valid=1 and not consumed.

## Timing
- Reset values: all respN_valid/result/zero/err = 0; last_grant = 1; reqN_ready combinationally 0 while rst=1.
- Latency: request accepted in cycle N -> respN_valid=1 in cycle N+1.
- Throughput: one accepted op per cycle total; per port, one per cycle when response consumed every cycle (back-to-back via simultaneous consume+accept).
- Port with pending unconsumed response never granted; other port may proceed.
- rst mid-operation: pending responses discarded, in-flight acceptance in reset cycle ignored.
- reqN_valid may drop without acceptance (no stickiness required of requester); arbiter holds no request state.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins contention; last_grant unused (may be removed). Port 1 served only when port 0 not eligible.
- Undefined (default): round-robin as above.

## Test plan
- Reset, then req0 ADD 5+7 -> req0_ready=1 same cycle; next cycle resp0_valid=1, result=12, zero=0, err=0.
- Both ports valid every cycle, responses always consumed: port0 SUB 3-3, port1 OR 0xF0|0x0F -> grants alternate 0,1,0,1; resp0 result 0 zero=1, resp1 result 0xFF.
- resp0_ready held 0 with req0_valid and req1_valid high -> port 0 granted once, then only port 1 granted; resp0_result stable until resp0_ready=1.
- req1 ctrl 4'b0011 -> accepted, alu_ctrl=0010 that cycle, resp1 result=0, zero=1, err=1.
- req0 SLT 0xFFFFFFFF,1 -> result 0 (unsigned); NOR 0,0 -> 0xFFFFFFFF; AND 0xF0F0,0xFF00 -> 0xF000.
- Assert rst while resp0_valid=1 -> resp0_valid=0 next cycle; with ALU_ARB_FIXED_PRIO_EN, contention grants port 0 every cycle.
